// File: rtl/sequencia_pkg.sv
// Shared definitions for the sequence generator and the sequence detector.
//
// Contents:
//   LARGURA_PADRAO    - default frame length in bits
//   estado_t          - generator FSM states (OCIOSO=0, ENVIANDO=1, FIM=2)
//   largura_contador  - width of a counter that indexes the bits of one frame
package sequencia_pkg;

    localparam int LARGURA_PADRAO = 16;

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        ENVIANDO = 2'd1,
        FIM      = 2'd2
    } estado_t;

    // A one-bit frame still needs a one-bit counter, so clamp at 1.
    function automatic int largura_contador(input int largura);
        if (largura > 1) begin
            return $clog2(largura);
        end
        return 1;
    endfunction

endpackage

// File: rtl/gerador_sequencia_if.sv
// Control and serial-output bundle of the sequence generator.
//
// Signals:
//   carregar    - load dado/repeticoes into the generator (idle only)
//   dado        - frame to transmit, LARGURA bits
//   repeticoes  - frame is sent repeticoes+1 times
//   start       - begin a transmission
//   abortar     - cancel a transmission in progress
//   bit_out     - serial bit, MSB first
//   bit_valido  - bit_out carries a frame bit this cycle
//   ocupado     - transmission in progress
//   fim         - one-cycle pulse on normal completion
//
// Modports:
//   master - the side that commands the generator and watches its output
//   slave  - the generator itself
interface gerador_sequencia_if #(
    parameter int LARGURA = sequencia_pkg::LARGURA_PADRAO
);

    logic               carregar;
    logic [LARGURA-1:0] dado;
    logic [3:0]         repeticoes;
    logic               start;
    logic               abortar;
    logic               bit_out;
    logic               bit_valido;
    logic               ocupado;
    logic               fim;

    modport master (
        output carregar,
        output dado,
        output repeticoes,
        output start,
        output abortar,
        input  bit_out,
        input  bit_valido,
        input  ocupado,
        input  fim
    );

    modport slave (
        input  carregar,
        input  dado,
        input  repeticoes,
        input  start,
        input  abortar,
        output bit_out,
        output bit_valido,
        output ocupado,
        output fim
    );

endinterface

// File: rtl/registrador_deslocamento.sv
// Frame register of the sequence generator.
//
// Keeps two copies of the frame: 'copia' is the latched frame that survives
// completion and abort, 'trabalho' is the working copy shifted left once per
// emitted bit. The serial bit is the MSB of 'trabalho', so it is a flop output.
//
// Ports:
//   clk, rst_n  - clock and asynchronous active-low reset (clears both copies)
//   carregar    - latch dado into the frame copy
//   recarregar  - restart the working copy from the frame (new value if
//                 carregar is asserted in the same cycle)
//   deslocar    - shift the working copy one bit to the left
//   limpar      - zero the working copy so the serial bit reads 0
//   dado        - parallel frame input
//   msb         - current serial bit
module registrador_deslocamento #(
    parameter int LARGURA = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               carregar,
    input  logic               recarregar,
    input  logic               deslocar,
    input  logic               limpar,
    input  logic [LARGURA-1:0] dado,
    output logic               msb
);

    logic [LARGURA-1:0] copia;
    logic [LARGURA-1:0] copia_prox;
    logic [LARGURA-1:0] trabalho;

    // A load and a start on the same edge must transmit the newly loaded
    // frame, so the working copy reloads from the post-load value.
    assign copia_prox = carregar ? dado : copia;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            copia <= '0;
        end else begin
            copia <= copia_prox;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trabalho <= '0;
        end else if (limpar) begin
            trabalho <= '0;
        end else if (recarregar) begin
            trabalho <= copia_prox;
        end else if (deslocar) begin
            trabalho <= trabalho << 1;
        end
    end

    assign msb = trabalho[LARGURA-1];

endmodule

// File: rtl/gerador_sequencia.sv
// Serial sequence generator.
//
// Sends a latched LARGURA-bit frame MSB first, repeticoes+1 times back to
// back, then pulses fim for one cycle. Every output is a flop.
//
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - gerador_sequencia_if.slave (load/start/abort in, serial out)
module gerador_sequencia
    import sequencia_pkg::*;
#(
    parameter int LARGURA = LARGURA_PADRAO
) (
    input  logic               clk,
    input  logic               rst_n,
    gerador_sequencia_if.slave bus
);

    localparam int            CW         = largura_contador(LARGURA);
    localparam logic [CW-1:0] ULTIMO_BIT = CW'(LARGURA - 1);

    estado_t       estado;
    estado_t       estado_prox;
    logic [CW-1:0] contador_bits;
    logic [CW-1:0] bits_prox;
    logic [3:0]    contador_rep;
    logic [3:0]    rep_prox;
    logic [3:0]    rep_guardado;

    logic          carregar_quadro;
    logic          recarregar;
    logic          deslocar;
    logic          limpar;

    logic          msb;
    logic          bit_valido_q;
    logic          ocupado_q;
    logic          fim_q;

    // Loads are accepted only while idle; a load during a transmission
    // must not disturb the frame being sent.
    assign carregar_quadro = bus.carregar && (estado == OCIOSO);

    registrador_deslocamento #(
        .LARGURA (LARGURA)
    ) u_registrador (
        .clk        (clk),
        .rst_n      (rst_n),
        .carregar   (carregar_quadro),
        .recarregar (recarregar),
        .deslocar   (deslocar),
        .limpar     (limpar),
        .dado       (bus.dado),
        .msb        (msb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado <= OCIOSO;
        end else begin
            estado <= estado_prox;
        end
    end

    // Next state and datapath controls. contador_bits indexes the bit being
    // emitted this cycle; on the last bit of a frame either the next
    // repetition is reloaded without a gap or the FSM moves to FIM.
    always_comb begin
        estado_prox = estado;
        bits_prox   = contador_bits;
        rep_prox    = contador_rep;
        recarregar  = 1'b0;
        deslocar    = 1'b0;
        limpar      = 1'b0;

        case (estado)
            OCIOSO: begin
                if (bus.start && !bus.abortar) begin
                    estado_prox = ENVIANDO;
                    recarregar  = 1'b1;
                    bits_prox   = '0;
                    rep_prox    = carregar_quadro ? bus.repeticoes : rep_guardado;
                end
            end

            ENVIANDO: begin
                if (bus.abortar) begin
                    estado_prox = OCIOSO;
                    limpar      = 1'b1;
                    bits_prox   = '0;
                    rep_prox    = '0;
                end else if (contador_bits == ULTIMO_BIT) begin
                    bits_prox = '0;
                    if (contador_rep == 4'd0) begin
                        estado_prox = FIM;
                        limpar      = 1'b1;
                    end else begin
                        rep_prox   = contador_rep - 4'd1;
                        recarregar = 1'b1;
                    end
                end else begin
                    bits_prox = contador_bits + CW'(1);
                    deslocar  = 1'b1;
                end
            end

            FIM: begin
                estado_prox = OCIOSO;
            end

            default: begin
                estado_prox = OCIOSO;
                limpar      = 1'b1;
                bits_prox   = '0;
                rep_prox    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            contador_bits <= '0;
            contador_rep  <= '0;
            rep_guardado  <= '0;
        end else begin
            contador_bits <= bits_prox;
            contador_rep  <= rep_prox;
            if (carregar_quadro) begin
                rep_guardado <= bus.repeticoes;
            end
        end
    end

    // Status flags are decoded from the next state so they line up with
    // the serial bit that the frame register presents in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_valido_q <= 1'b0;
            ocupado_q    <= 1'b0;
            fim_q        <= 1'b0;
        end else begin
            bit_valido_q <= (estado_prox == ENVIANDO);
            ocupado_q    <= (estado_prox != OCIOSO);
            fim_q        <= (estado_prox == FIM);
        end
    end

    assign bus.bit_out    = msb;
    assign bus.bit_valido = bit_valido_q;
    assign bus.ocupado    = ocupado_q;
    assign bus.fim        = fim_q;

endmodule

// File: tb/tb_gerador_sequencia.sv
// Self-checking bench for gerador_sequencia with hand-computed directed vectors.
module tb_gerador_sequencia;

    localparam int LARGURA = 16;
    localparam int LIMITE  = 400;

    logic clk;
    logic rst_n;

    int vetores;
    int erros;

    logic [511:0] cap_bits;
    int           cap_n_validos;
    int           cap_n_fim;
    int           cap_ciclo_fim;
    int           cap_ciclo_livre;
    int           cap_rajadas;
    bit           cap_erro_bit0;

    gerador_sequencia_if #(.LARGURA(LARGURA)) bus ();

    gerador_sequencia #(
        .LARGURA (LARGURA)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic esperar_borda();
        @(posedge clk);
        #1;
    endtask

    // Drives start (optionally with a load) across one edge; returns in cycle 1.
    task automatic iniciar(input logic com_carga, input logic [15:0] quadro, input logic [3:0] rep);
        bus.carregar   = com_carga;
        bus.dado       = quadro;
        bus.repeticoes = rep;
        bus.start      = 1'b1;
        esperar_borda();
        bus.carregar   = 1'b0;
        bus.start      = 1'b0;
    endtask

    // Records the transmission from cycle 1 until ocupado drops; optionally
    // drives abortar, a start+load disturbance, or a lone start in given cycles.
    task automatic capturar(input int ciclo_abortar, input int ciclo_perturbar, input int ciclo_start);
        logic ant_valido;
        bit   terminou;
        cap_bits        = '0;
        cap_n_validos   = 0;
        cap_n_fim       = 0;
        cap_ciclo_fim   = 0;
        cap_ciclo_livre = 0;
        cap_rajadas     = 0;
        cap_erro_bit0   = 1'b0;
        ant_valido      = 1'b0;
        terminou        = 1'b0;
        for (int c = 1; c <= LIMITE; c++) begin
            if (bus.bit_valido === 1'b1) begin
                cap_bits = {cap_bits[510:0], bus.bit_out};
                cap_n_validos++;
                if (!ant_valido) cap_rajadas++;
            end else if (bus.bit_out !== 1'b0) begin
                cap_erro_bit0 = 1'b1;
            end
            ant_valido = (bus.bit_valido === 1'b1);
            if (bus.fim === 1'b1) begin
                cap_n_fim++;
                cap_ciclo_fim = c;
            end
            if (bus.ocupado !== 1'b1) begin
                cap_ciclo_livre = c;
                terminou = 1'b1;
                break;
            end
            if (c == ciclo_abortar) bus.abortar = 1'b1;
            if (c == ciclo_perturbar) begin
                bus.start    = 1'b1;
                bus.carregar = 1'b1;
                bus.dado     = 16'h1234;
            end
            if (c == ciclo_start) bus.start = 1'b1;
            esperar_borda();
            bus.abortar  = 1'b0;
            bus.start    = 1'b0;
            bus.carregar = 1'b0;
        end
        vetores++;
        if (!terminou) begin
            erros++;
            $display("[TB] FAIL capture_timeout: ocupado still 1 after %0d cycles, expected 0", LIMITE);
        end
    endtask

    function automatic bit contem_palavra(input logic [511:0] b, input int n, input logic [7:0] p);
        for (int i = 0; i + 8 <= n; i++) begin
            if (b[i +: 8] === p) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        esperar_borda();
        esperar_borda();
        vetores++; if (bus.bit_out !== 1'b0)    begin erros++; $display("[TB] FAIL reset_bit_out: got %b expected 0", bus.bit_out); end
        vetores++; if (bus.bit_valido !== 1'b0) begin erros++; $display("[TB] FAIL reset_bit_valido: got %b expected 0", bus.bit_valido); end
        vetores++; if (bus.ocupado !== 1'b0)    begin erros++; $display("[TB] FAIL reset_ocupado: got %b expected 0", bus.ocupado); end
        vetores++; if (bus.fim !== 1'b0)        begin erros++; $display("[TB] FAIL reset_fim: got %b expected 0", bus.fim); end
        rst_n = 1'b1;
        esperar_borda();
    endtask

    task automatic test_zero_frame();
        iniciar(1'b0, 16'hFFFF, 4'd0);
        capturar(0, 0, 0);
        vetores++; if (cap_n_validos != 16)      begin erros++; $display("[TB] FAIL zero_count: got %0d expected 16", cap_n_validos); end
        vetores++; if (cap_bits[15:0] !== 16'h0) begin erros++; $display("[TB] FAIL zero_bits: got %h expected 0000", cap_bits[15:0]); end
        vetores++; if (cap_n_fim != 1)           begin erros++; $display("[TB] FAIL zero_fim: got %0d expected 1", cap_n_fim); end
    endtask

    task automatic test_basic();
        iniciar(1'b1, 16'hA5C3, 4'd0);
        capturar(0, 0, 0);
        vetores++; if (cap_n_validos != 16)         begin erros++; $display("[TB] FAIL basic_count: got %0d expected 16", cap_n_validos); end
        vetores++; if (cap_bits[15:0] !== 16'hA5C3) begin erros++; $display("[TB] FAIL basic_bits: got %h expected a5c3", cap_bits[15:0]); end
        vetores++; if (cap_rajadas != 1)            begin erros++; $display("[TB] FAIL basic_bursts: got %0d expected 1", cap_rajadas); end
        vetores++; if (cap_n_fim != 1)              begin erros++; $display("[TB] FAIL basic_fim_count: got %0d expected 1", cap_n_fim); end
        vetores++; if (cap_ciclo_fim != 17)         begin erros++; $display("[TB] FAIL basic_fim_cycle: got %0d expected 17", cap_ciclo_fim); end
        vetores++; if (cap_ciclo_livre != 18)       begin erros++; $display("[TB] FAIL basic_idle_cycle: got %0d expected 18", cap_ciclo_livre); end
        vetores++; if (cap_erro_bit0)               begin erros++; $display("[TB] FAIL basic_bit_out_idle: got 1 expected 0 while bit_valido=0"); end
    endtask

    task automatic test_repeticoes();
        bus.carregar   = 1'b1;
        bus.dado       = 16'h8001;
        bus.repeticoes = 4'd2;
        esperar_borda();
        bus.carregar   = 1'b0;
        vetores++; if (bus.ocupado !== 1'b0) begin erros++; $display("[TB] FAIL load_only_ocupado: got %b expected 0", bus.ocupado); end
        iniciar(1'b0, 16'h0000, 4'd0);
        capturar(0, 0, 0);
        vetores++; if (cap_n_validos != 48)                  begin erros++; $display("[TB] FAIL rep_count: got %0d expected 48", cap_n_validos); end
        vetores++; if (cap_bits[47:0] !== {3{16'h8001}})     begin erros++; $display("[TB] FAIL rep_bits: got %h expected 800180018001", cap_bits[47:0]); end
        vetores++; if (cap_rajadas != 1)                     begin erros++; $display("[TB] FAIL rep_bursts: got %0d expected 1", cap_rajadas); end
        vetores++; if (cap_n_fim != 1 || cap_ciclo_fim != 49) begin erros++; $display("[TB] FAIL rep_fim: got %0d pulses at cycle %0d expected 1 at 49", cap_n_fim, cap_ciclo_fim); end
    endtask

    task automatic test_max_rep();
        iniciar(1'b1, 16'hA5C3, 4'd15);
        capturar(0, 0, 0);
        vetores++; if (cap_n_validos != 256)               begin erros++; $display("[TB] FAIL maxrep_count: got %0d expected 256", cap_n_validos); end
        vetores++; if (cap_bits[255:0] !== {16{16'hA5C3}}) begin erros++; $display("[TB] FAIL maxrep_bits: got %h expected 16 x a5c3", cap_bits[255:0]); end
        vetores++; if (cap_ciclo_fim != 257)               begin erros++; $display("[TB] FAIL maxrep_fim_cycle: got %0d expected 257", cap_ciclo_fim); end
    endtask

    task automatic test_abort();
        iniciar(1'b1, 16'hFFFF, 4'd0);
        capturar(5, 0, 0);
        vetores++; if (cap_n_validos != 5)    begin erros++; $display("[TB] FAIL abort_count: got %0d expected 5", cap_n_validos); end
        vetores++; if (cap_ciclo_livre != 6)  begin erros++; $display("[TB] FAIL abort_idle_cycle: got %0d expected 6", cap_ciclo_livre); end
        vetores++; if (cap_n_fim != 0)        begin erros++; $display("[TB] FAIL abort_fim: got %0d expected 0", cap_n_fim); end
        vetores++; if (cap_erro_bit0)         begin erros++; $display("[TB] FAIL abort_bit_out_idle: got 1 expected 0"); end
        iniciar(1'b0, 16'h0000, 4'd0);
        capturar(0, 0, 0);
        vetores++; if (cap_n_validos != 16)         begin erros++; $display("[TB] FAIL abort_restart_count: got %0d expected 16", cap_n_validos); end
        vetores++; if (cap_bits[15:0] !== 16'hFFFF) begin erros++; $display("[TB] FAIL abort_restart_bits: got %h expected ffff", cap_bits[15:0]); end
        vetores++; if (cap_n_fim != 1)              begin erros++; $display("[TB] FAIL abort_restart_fim: got %0d expected 1", cap_n_fim); end
    endtask

    task automatic test_abort_priority();
        bus.start   = 1'b1;
        bus.abortar = 1'b1;
        esperar_borda();
        bus.start   = 1'b0;
        bus.abortar = 1'b0;
        vetores++; if (bus.ocupado !== 1'b0)    begin erros++; $display("[TB] FAIL prio_ocupado: got %b expected 0", bus.ocupado); end
        vetores++; if (bus.bit_valido !== 1'b0) begin erros++; $display("[TB] FAIL prio_bit_valido: got %b expected 0", bus.bit_valido); end
    endtask

    task automatic test_ignore();
        iniciar(1'b1, 16'h5A0F, 4'd1);
        capturar(0, 7, 33);
        vetores++; if (cap_n_validos != 32)              begin erros++; $display("[TB] FAIL ignore_count: got %0d expected 32", cap_n_validos); end
        vetores++; if (cap_bits[31:0] !== {2{16'h5A0F}}) begin erros++; $display("[TB] FAIL ignore_bits: got %h expected 5a0f5a0f", cap_bits[31:0]); end
        vetores++; if (cap_ciclo_livre != 34)            begin erros++; $display("[TB] FAIL ignore_idle_cycle: got %0d expected 34", cap_ciclo_livre); end
        esperar_borda();
        vetores++; if (bus.ocupado !== 1'b0)             begin erros++; $display("[TB] FAIL ignore_no_queue: got %b expected 0", bus.ocupado); end
        iniciar(1'b0, 16'h1234, 4'd0);
        capturar(0, 0, 0);
        vetores++; if (cap_n_validos != 32)              begin erros++; $display("[TB] FAIL retransmit_count: got %0d expected 32", cap_n_validos); end
        vetores++; if (cap_bits[31:0] !== {2{16'h5A0F}}) begin erros++; $display("[TB] FAIL retransmit_bits: got %h expected 5a0f5a0f", cap_bits[31:0]); end
    endtask

    task automatic test_reset_mid();
        iniciar(1'b1, 16'hFFFF, 4'd3);
        for (int i = 0; i < 6; i++) esperar_borda();
        vetores++; if (bus.bit_valido !== 1'b1 || bus.bit_out !== 1'b1) begin erros++; $display("[TB] FAIL midrst_before: got valido=%b bit=%b expected 1 1", bus.bit_valido, bus.bit_out); end
        #3;
        rst_n = 1'b0;
        #1;
        vetores++; if (bus.bit_out !== 1'b0)    begin erros++; $display("[TB] FAIL midrst_bit_out: got %b expected 0", bus.bit_out); end
        vetores++; if (bus.bit_valido !== 1'b0) begin erros++; $display("[TB] FAIL midrst_bit_valido: got %b expected 0", bus.bit_valido); end
        vetores++; if (bus.ocupado !== 1'b0)    begin erros++; $display("[TB] FAIL midrst_ocupado: got %b expected 0", bus.ocupado); end
        #2;
        rst_n = 1'b1;
        esperar_borda();
        vetores++; if (bus.ocupado !== 1'b0 || bus.fim !== 1'b0) begin erros++; $display("[TB] FAIL midrst_after: got ocupado=%b fim=%b expected 0 0", bus.ocupado, bus.fim); end
        iniciar(1'b0, 16'hFFFF, 4'd3);
        capturar(0, 0, 0);
        vetores++; if (cap_n_validos != 16)      begin erros++; $display("[TB] FAIL midrst_restart_count: got %0d expected 16", cap_n_validos); end
        vetores++; if (cap_bits[15:0] !== 16'h0) begin erros++; $display("[TB] FAIL midrst_restart_bits: got %h expected 0000", cap_bits[15:0]); end
    endtask

    task automatic test_loopback();
        iniciar(1'b1, 16'h00A5, 4'd0);
        capturar(0, 0, 0);
        vetores++; if (contem_palavra(cap_bits, cap_n_validos, 8'hA5) !== 1'b1) begin erros++; $display("[TB] FAIL loop_found: got 0 expected 1 for frame 00a5"); end
        iniciar(1'b1, 16'h0000, 4'd0);
        capturar(0, 0, 0);
        vetores++; if (cap_n_validos != 16)                                     begin erros++; $display("[TB] FAIL loop_zero_count: got %0d expected 16", cap_n_validos); end
        vetores++; if (contem_palavra(cap_bits, cap_n_validos, 8'hA5) !== 1'b0) begin erros++; $display("[TB] FAIL loop_not_found: got 1 expected 0 for frame 0000"); end
    endtask

    initial begin
        vetores        = 0;
        erros          = 0;
        rst_n          = 1'b0;
        bus.carregar   = 1'b0;
        bus.dado       = '0;
        bus.repeticoes = '0;
        bus.start      = 1'b0;
        bus.abortar    = 1'b0;

        test_reset();
        test_zero_frame();
        test_basic();
        test_repeticoes();
        test_max_rep();
        test_abort();
        test_abort_priority();
        test_ignore();
        test_reset_mid();
        test_loopback();

        $display("== %0d vectors applied, %0d miscompares ==", vetores, erros);
        $finish;
    end

endmodule

// File: doc/gerador_sequencia.md
GERADOR_SEQUENCIA -- requirements
Module: gerador_sequencia

Interface
REQ-001 Parameter LARGURA, default 16, defines the frame length in bits.
REQ-002 Port clk, input, 1; sole clock, rising edge.
REQ-003 Port rst_n, input, 1; asynchronous, active-low reset.
REQ-004 Port carregar, input, 1; loads dado into the frame register.
REQ-005 Port dado, input, LARGURA; frame to transmit.
REQ-006 Port repeticoes, input, 4; frame is sent repeticoes+1 times.
REQ-007 Port start, input, 1; begins transmission.
REQ-008 Port abortar, input, 1; cancels transmission.
REQ-009 Port bit_out, output, 1; serial bit, MSB first.
REQ-010 Port bit_valido, output, 1; bit_out carries a frame bit this cycle.
REQ-011 Port ocupado, output, 1; transmission in progress.
REQ-012 Port fim, output, 1; one-cycle pulse at normal completion.

Function
REQ-013 The FSM SHALL have exactly the states OCIOSO, ENVIANDO and FIM.
REQ-014 In OCIOSO, carregar=1 SHALL latch dado and repeticoes at the clock edge; carregar in any other state SHALL be ignored.
REQ-015 In OCIOSO, start=1 at edge N SHALL enter ENVIANDO; bit_out=frame[LARGURA-1] and bit_valido=1 SHALL appear in cycle N+1.
REQ-016 If carregar and start are both 1 at the same edge in OCIOSO, the newly loaded dado SHALL be the frame transmitted.
REQ-017 start without any prior load SHALL transmit the reset frame, all zeros.
REQ-018 In ENVIANDO, one bit SHALL be emitted per cycle, MSB to LSB, with bit_valido held at 1 and no gaps between bits or between repetitions.
REQ-019 A bit counter (width clog2(LARGURA)) SHALL wrap from LARGURA-1 to 0 at each frame boundary, and a repetition counter SHALL decrement at each boundary.
REQ-020 After bit 0 of the final repetition, the FSM SHALL enter FIM for exactly one cycle with fim=1, bit_valido=0 and bit_out=0, then return to OCIOSO.
REQ-021 Total bit_valido cycles per transmission SHALL equal LARGURA*(repeticoes+1); repeticoes=15 with LARGURA=16 SHALL give 256.
REQ-022 start while in ENVIANDO or FIM SHALL be ignored, with no restart and no queuing.
REQ-023 abortar=1 in ENVIANDO SHALL return the FSM to OCIOSO at that edge: bit_valido=0 next cycle, and no fim pulse.
REQ-024 abortar SHALL have priority over start when both are 1.
REQ-025 The latched frame SHALL be preserved after completion or abort, so a new start retransmits it.
REQ-026 ocupado SHALL be 1 in ENVIANDO and FIM and 0 in OCIOSO.
REQ-027 bit_out SHALL be 0 whenever bit_valido=0.
REQ-028 All outputs SHALL be registered.

Reset
REQ-029 rst_n=0 SHALL immediately force OCIOSO, clear the frame and all counters, and set bit_out=0, bit_valido=0, ocupado=0 and fim=0, regardless of clk.
REQ-030 Reset asserted mid-transmission SHALL terminate it with no fim pulse; after release, start SHALL send the zero frame.

Structure
REQ-031 The state encoding (OCIOSO=0, ENVIANDO=1, FIM=2) and the default LARGURA SHALL be defined in the shared package sequencia_pkg, which is also used by the detector.
REQ-032 The parallel-load, left-shifting frame register SHALL be a sub-module named registrador_deslocamento, with load, shift and reload-from-latched-copy controls.

Verification
REQ-033 Load 0xA5C3, repeticoes=0, start at edge 0 -> bit_out 1010010111000011 on cycles 1-16 with bit_valido=1, fim=1 on cycle 17, ocupado=0 on cycle 18.
REQ-034 Load 0x8001, repeticoes=2 -> 48 contiguous valid bits (pattern repeated 3x) and a single fim pulse.
REQ-035 Abort on cycle 5 of a 0xFFFF transmission -> bit_valido=0 from cycle 6, fim never asserted, and a restart resends all 16 ones.
REQ-036 start pulses during ENVIANDO and carregar=0x1234 mid-transmission -> transmission unaffected; the next start still sends the original frame.
REQ-037 rst_n low between clock edges on cycle 7 -> outputs clear immediately; the next start after release sends 16 zeros.
REQ-038 Loopback into the detector (palavra=0xA5, frame 0x00A5) -> encontrado=1; frame 0x0000 -> encontrado=0.
